// File: rtl/backprop_pkg.sv
// Shared types and helpers for the backprop systolic array front end.
// Holds the feeder FSM state encoding and a lane-extraction helper for row buses.
package backprop_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } feeder_state_t;

  localparam int unsigned LANE_MAX_W = 64;
  localparam int unsigned BUS_MAX_W  = 1024;

  // Lane k of a lanes*lane_w bus; lane 0 is the most significant slice.
  function automatic logic [LANE_MAX_W-1:0] lane_slice(
    input logic [BUS_MAX_W-1:0] word,
    input int unsigned          k,
    input int unsigned          lane_w,
    input int unsigned          lanes
  );
    logic [BUS_MAX_W-1:0]  shifted;
    logic [LANE_MAX_W-1:0] mask;
    shifted = word >> (lane_w * (lanes - 1 - k));
    mask    = (lane_w >= LANE_MAX_W) ? '1
                                     : ((LANE_MAX_W'(1) << lane_w) - LANE_MAX_W'(1));
    return LANE_MAX_W'(shifted) & mask;
  endfunction

endpackage

// File: rtl/z_stream_feeder_if.sv
// Row-write, frame-control and skewed-output signals of the z stream feeder.
// master drives rows and frame requests; slave is the feeder itself.
interface z_stream_feeder_if #(
  parameter int unsigned data_size = 16,
  parameter int unsigned size      = 3,
  parameter int unsigned depth     = 8
);
  localparam int unsigned row_w = data_size * size;
  localparam int unsigned cnt_w = $clog2(depth) + 1;

  logic             wr_valid;
  logic             wr_ready;
  logic [row_w-1:0] wr_data;
  logic             start;
  logic [cnt_w-1:0] frame_len;
  logic             busy;
  logic [row_w-1:0] z_to_z;
  logic             z_valid;
  logic             reset_counter_out;
  logic             done;
  logic [cnt_w-1:0] fill;

  modport master (
    output wr_valid, wr_data, start, frame_len,
    input  wr_ready, busy, z_to_z, z_valid, reset_counter_out, done, fill
  );

  modport slave (
    input  wr_valid, wr_data, start, frame_len,
    output wr_ready, busy, z_to_z, z_valid, reset_counter_out, done, fill
  );

endinterface

// File: rtl/skew_line.sv
// One lane's delay line: stages registers with asynchronous active-low reset.
// stages == 0 degenerates to a plain wire.
module skew_line #(
  parameter int unsigned width  = 16,
  parameter int unsigned stages = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] d_i,
  output logic [width-1:0] q_o
);

  if (stages == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign q_o = d_i;
  end else begin : g_shift
    logic [width-1:0] pipe_q [stages];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(stages); i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= d_i;
        for (int i = 1; i < int'(stages); i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign q_o = pipe_q[stages-1];
  end

endmodule

// File: rtl/z_stream_feeder.sv
// Buffers z rows in a FIFO and releases them as diagonally skewed frames with
// frame-start and done pulses. Z_STREAM_FEEDER_STALL_CNT_EN adds stall_cycles.
module z_stream_feeder
  import backprop_pkg::*;
#(
  parameter int unsigned data_size = 16,
  parameter int unsigned size      = 3,
  parameter int unsigned depth     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  z_stream_feeder_if.slave bus
`ifdef Z_STREAM_FEEDER_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cycles
`endif
);

  localparam int unsigned row_w = data_size * size;
  localparam int unsigned aw    = (depth > 1) ? $clog2(depth) : 1;
  localparam int unsigned cnt_w = $clog2(depth) + 1;
  localparam int unsigned sz_w  = $clog2(size) + 1;
  localparam int unsigned ctr_w = (cnt_w > sz_w) ? cnt_w : sz_w;

  // ---------------- row FIFO ----------------
  logic [row_w-1:0] mem_q [depth];
  logic [aw-1:0]    wr_ptr_q, rd_ptr_q;
  logic [cnt_w-1:0] count_q, count_d;
  logic             wr_ready_q;
  logic             push_c, pop_c;

  // Ready comes from registered occupancy, so a same-cycle pop never admits a push.
  assign push_c  = bus.wr_valid && wr_ready_q;
  assign count_d = count_q + cnt_w'(push_c) - cnt_w'(pop_c);

  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wr_ready_q <= 1'b1;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + aw'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + aw'(1);
      count_q    <= count_d;
      wr_ready_q <= (count_d != cnt_w'(depth));
    end
  end

  // ---------------- frame FSM ----------------
  feeder_state_t    state_q, state_d;
  logic [ctr_w-1:0] len_q, len_d;
  logic [ctr_w-1:0] cnt_q, cnt_d;
  logic [ctr_w-1:0] len_clamp_c;
  logic             first_c, done_c;

  assign len_clamp_c = (bus.frame_len > cnt_w'(depth)) ? ctr_w'(depth)
                                                       : ctr_w'(bus.frame_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q counts popped rows in STREAM and remaining wait cycles in DRAIN.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          len_d   = len_clamp_c;
          cnt_d   = '0;
          state_d = (len_clamp_c == '0) ? DRAIN : WAIT;
        end
      end
      WAIT: begin
        if (ctr_w'(count_q) >= len_q) begin
          state_d = STREAM;
          cnt_d   = '0;
        end
      end
      STREAM: begin
        cnt_d = cnt_q + ctr_w'(1);
        if (cnt_q == len_q - ctr_w'(1)) begin
          if (size == 1) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = DRAIN;
            cnt_d   = ctr_w'(size - 2);
          end
        end
      end
      DRAIN: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - ctr_w'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop_c   = 1'b0;
    first_c = 1'b0;
    done_c  = 1'b0;
    pop_c   = (state_q == STREAM);
    first_c = pop_c && (cnt_q == '0);
    done_c  = (state_q != IDLE) && (state_d == IDLE);
  end

  // ---------------- registered outputs and lane-0 stage ----------------
  logic             busy_q, done_q, z_valid_q, rc_q;
  logic [row_w-1:0] row_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      z_valid_q <= 1'b0;
      rc_q      <= 1'b0;
      row_q     <= '0;
    end else begin
      busy_q    <= (state_d != IDLE);
      done_q    <= done_c;
      z_valid_q <= pop_c;
      rc_q      <= first_c;
      row_q     <= pop_c ? mem_q[rd_ptr_q] : '0;
    end
  end

  // Lane k sees k extra register stages after the shared row register.
  logic [row_w-1:0] z_row_c;

  for (genvar k = 0; k < int'(size); k++) begin : g_lane
    logic [data_size-1:0] lane_in;
    logic [data_size-1:0] lane_out;

    assign lane_in = data_size'(lane_slice(BUS_MAX_W'(row_q), k, data_size, size));

    skew_line #(
      .width (data_size),
      .stages(k)
    ) u_skew (
      .clk  (clk),
      .rst_n(rst_n),
      .d_i  (lane_in),
      .q_o  (lane_out)
    );

    assign z_row_c[data_size*(size-k)-1 -: data_size] = lane_out;
  end

  assign bus.wr_ready          = wr_ready_q;
  assign bus.fill              = count_q;
  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
  assign bus.z_valid           = z_valid_q;
  assign bus.reset_counter_out = rc_q;
  assign bus.z_to_z            = z_row_c;

`ifdef Z_STREAM_FEEDER_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (state_q == IDLE && bus.start) begin
      stall_q <= '0;
    end else if (state_q == WAIT && stall_q != '1) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_z_stream_feeder.sv
// Directed self-checking bench for z_stream_feeder (data_size=16, size=3, depth=8).
// Checks stall_cycles too when Z_STREAM_FEEDER_STALL_CNT_EN is defined.
module tb_z_stream_feeder;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  z_stream_feeder_if #(.data_size(16), .size(3), .depth(8)) bus ();

`ifdef Z_STREAM_FEEDER_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  z_stream_feeder #(.data_size(16), .size(3), .depth(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
`ifdef Z_STREAM_FEEDER_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] mk_row(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] c);
    return {a, b, c};
  endfunction

  task automatic push_row(input logic [47:0] r);
    bus.wr_valid = 1'b1;
    bus.wr_data  = r;
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.start     = 1'b0;
    bus.frame_len = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.fill !== 4'd0) begin n_bad++; $display("FAIL reset_fill: got %0d exp 0", bus.fill); end
    n_cmp++; if (bus.wr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_wr_ready: got %b exp 1", bus.wr_ready); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b exp 0", bus.busy); end
    n_cmp++; if (bus.z_valid !== 1'b0) begin n_bad++; $display("FAIL reset_z_valid: got %b exp 0", bus.z_valid); end
    n_cmp++; if (bus.z_to_z !== 48'h0) begin n_bad++; $display("FAIL reset_z_to_z: got %h exp 0", bus.z_to_z); end
    n_cmp++; if (bus.reset_counter_out !== 1'b0) begin n_bad++; $display("FAIL reset_rc: got %b exp 0", bus.reset_counter_out); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b exp 0", bus.done); end
`ifdef Z_STREAM_FEEDER_STALL_CNT_EN
    n_cmp++; if (stall_cycles !== 32'd0) begin n_bad++; $display("FAIL reset_stall: got %0d exp 0", stall_cycles); end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_frame();
    logic [47:0] exp_z [1:9];
    logic [9:1]  exp_v, exp_rc, exp_done, exp_busy;
    logic [3:0]  got_s, exp_s;
    exp_z[1] = 48'h0; exp_z[2] = 48'h0;
    exp_z[3] = 48'h0001_0000_0000;
    exp_z[4] = 48'h0004_0002_0000;
    exp_z[5] = 48'h0007_0005_0003;
    exp_z[6] = 48'h0000_0008_0006;
    exp_z[7] = 48'h0000_0000_0009;
    exp_z[8] = 48'h0; exp_z[9] = 48'h0;
    exp_v    = 9'b000011100;
    exp_rc   = 9'b000000100;
    exp_done = 9'b001000000;
    exp_busy = 9'b000111111;
    push_row(48'h0001_0002_0003);
    push_row(48'h0004_0005_0006);
    push_row(48'h0007_0008_0009);
    n_cmp++; if (bus.fill !== 4'd3) begin n_bad++; $display("FAIL basic_fill3: got %0d exp 3", bus.fill); end
    bus.start = 1'b1; bus.frame_len = 4'd3;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      got_s = {bus.z_valid, bus.reset_counter_out, bus.done, bus.busy};
      exp_s = {exp_v[c], exp_rc[c], exp_done[c], exp_busy[c]};
      n_cmp++; if (bus.z_to_z !== exp_z[c]) begin n_bad++; $display("FAIL basic_z c%0d: got %h exp %h", c, bus.z_to_z, exp_z[c]); end
      n_cmp++; if (got_s !== exp_s) begin n_bad++; $display("FAIL basic_ctl{v,rc,done,busy} c%0d: got %b exp %b", c, got_s, exp_s); end
      tick();
    end
    n_cmp++; if (bus.fill !== 4'd0) begin n_bad++; $display("FAIL basic_fill_end: got %0d exp 0", bus.fill); end
`ifdef Z_STREAM_FEEDER_STALL_CNT_EN
    n_cmp++; if (stall_cycles !== 32'd1) begin n_bad++; $display("FAIL basic_stall: got %0d exp 1", stall_cycles); end
`endif
  endtask

  task automatic test_wait_stall();
    int nv;
    bit seen_done;
    push_row(mk_row(16'h000A, 16'h000B, 16'h000C));
    push_row(mk_row(16'h000D, 16'h000E, 16'h000F));
    bus.start = 1'b1; bus.frame_len = 4'd4;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      n_cmp++; if (bus.z_valid !== 1'b0 || bus.busy !== 1'b1) begin n_bad++; $display("FAIL wait_hold c%0d: got v=%b busy=%b exp v=0 busy=1", c, bus.z_valid, bus.busy); end
      if (c < 3) tick();
    end
    push_row(mk_row(16'h0010, 16'h0011, 16'h0012));
    push_row(mk_row(16'h0013, 16'h0014, 16'h0015));
    n_cmp++; if (bus.z_valid !== 1'b0 || bus.fill !== 4'd4) begin n_bad++; $display("FAIL wait_c5: got v=%b fill=%0d exp v=0 fill=4", bus.z_valid, bus.fill); end
    tick();
    n_cmp++; if (bus.z_valid !== 1'b0) begin n_bad++; $display("FAIL wait_c6_valid: got %b exp 0", bus.z_valid); end
`ifdef Z_STREAM_FEEDER_STALL_CNT_EN
    n_cmp++; if (stall_cycles !== 32'd5) begin n_bad++; $display("FAIL wait_stall: got %0d exp 5", stall_cycles); end
`endif
    tick();
    n_cmp++; if (bus.z_valid !== 1'b1 || bus.reset_counter_out !== 1'b1) begin n_bad++; $display("FAIL wait_first_row: got v=%b rc=%b exp 1 1", bus.z_valid, bus.reset_counter_out); end
    n_cmp++; if (bus.z_to_z !== 48'h000A_0000_0000) begin n_bad++; $display("FAIL wait_first_z: got %h exp 000a00000000", bus.z_to_z); end
    nv = 0; seen_done = 1'b0;
    for (int i = 0; i < 20 && !seen_done; i++) begin
      if (bus.z_valid) nv++;
      if (bus.done) seen_done = 1'b1; else tick();
    end
    n_cmp++; if (seen_done !== 1'b1) begin n_bad++; $display("FAIL wait_done_timeout: got %b exp 1", seen_done); end
    n_cmp++; if (nv !== 4) begin n_bad++; $display("FAIL wait_rows: got %0d exp 4", nv); end
    tick();
  endtask

  task automatic test_fifo_full_clamp();
    int nv, ndone;
    bit seen_done;
    logic [15:0] first_l0, last_l0;
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.wr_data = mk_row(16'(16'h0100 + i), 16'(16'h0200 + i), 16'(16'h0300 + i));
      tick();
    end
    bus.wr_data = mk_row(16'h0108, 16'h0208, 16'h0308);
    n_cmp++; if (bus.wr_ready !== 1'b0 || bus.fill !== 4'd8) begin n_bad++; $display("FAIL full_level: got ready=%b fill=%0d exp 0 8", bus.wr_ready, bus.fill); end
    bus.start = 1'b1; bus.frame_len = 4'd1;
    tick();
    bus.start = 1'b0;
    n_cmp++; if (bus.wr_ready !== 1'b0 || bus.fill !== 4'd8) begin n_bad++; $display("FAIL full_c1: got ready=%b fill=%0d exp 0 8", bus.wr_ready, bus.fill); end
    tick();
    n_cmp++; if (bus.wr_ready !== 1'b0) begin n_bad++; $display("FAIL full_pop_cycle_ready: got %b exp 0", bus.wr_ready); end
    tick();
    n_cmp++; if (bus.wr_ready !== 1'b1 || bus.fill !== 4'd7) begin n_bad++; $display("FAIL full_after_pop: got ready=%b fill=%0d exp 1 7", bus.wr_ready, bus.fill); end
    n_cmp++; if (bus.z_to_z !== 48'h0100_0000_0000) begin n_bad++; $display("FAIL full_pop_z: got %h exp 010000000000", bus.z_to_z); end
    tick();
    bus.wr_valid = 1'b0;
    n_cmp++; if (bus.fill !== 4'd8 || bus.wr_ready !== 1'b0) begin n_bad++; $display("FAIL full_ninth_accepted: got fill=%0d ready=%b exp 8 0", bus.fill, bus.wr_ready); end
    tick();
    n_cmp++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL full_done: got done=%b busy=%b exp 1 0", bus.done, bus.busy); end
    // frame_len=15 must clamp to 8; a start mid-frame must be ignored
    bus.start = 1'b1; bus.frame_len = 4'd15;
    tick();
    bus.start = 1'b0;
    nv = 0; seen_done = 1'b0; first_l0 = '0; last_l0 = '0;
    for (int i = 0; i < 40 && !seen_done; i++) begin
      if (i == 3) begin bus.start = 1'b1; bus.frame_len = 4'd1; end
      if (i == 4) bus.start = 1'b0;
      if (bus.reset_counter_out) first_l0 = bus.z_to_z[47:32];
      if (bus.z_valid) begin nv++; last_l0 = bus.z_to_z[47:32]; end
      if (bus.done) seen_done = 1'b1; else tick();
    end
    bus.start = 1'b0;
    n_cmp++; if (seen_done !== 1'b1) begin n_bad++; $display("FAIL clamp_done_timeout: got %b exp 1", seen_done); end
    n_cmp++; if (nv !== 8) begin n_bad++; $display("FAIL clamp_rows: got %0d exp 8", nv); end
    n_cmp++; if (first_l0 !== 16'h0101) begin n_bad++; $display("FAIL clamp_first: got %h exp 0101", first_l0); end
    n_cmp++; if (last_l0 !== 16'h0108) begin n_bad++; $display("FAIL clamp_last: got %h exp 0108", last_l0); end
    nv = 0; ndone = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.z_valid || bus.busy) nv++;
      if (bus.done) ndone++;
    end
    n_cmp++; if (nv !== 0 || ndone !== 0) begin n_bad++; $display("FAIL busy_start_ignored: got active=%0d done=%0d exp 0 0", nv, ndone); end
    n_cmp++; if (bus.fill !== 4'd0) begin n_bad++; $display("FAIL clamp_fill_end: got %0d exp 0", bus.fill); end
  endtask

  task automatic test_zero_len();
    int nv;
    nv = 0;
    bus.start = 1'b1; bus.frame_len = 4'd0;
    tick();
    bus.start = 1'b0;
    n_cmp++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin n_bad++; $display("FAIL zero_c1: got busy=%b done=%b exp 1 0", bus.busy, bus.done); end
    if (bus.z_valid || bus.reset_counter_out) nv++;
    tick();
    n_cmp++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL zero_done: got done=%b busy=%b exp 1 0", bus.done, bus.busy); end
    if (bus.z_valid || bus.reset_counter_out) nv++;
    tick();
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL zero_done_width: got %b exp 0", bus.done); end
    if (bus.z_valid || bus.reset_counter_out) nv++;
    n_cmp++; if (nv !== 0) begin n_bad++; $display("FAIL zero_no_rows: got %0d exp 0", nv); end
  endtask

  task automatic test_reset_mid();
    int nd;
    push_row(48'h0041_0042_0043);
    push_row(48'h0044_0045_0046);
    push_row(48'h0047_0048_0049);
    bus.start = 1'b1; bus.frame_len = 4'd3;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    n_cmp++; if (bus.z_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_streaming: got %b exp 1", bus.z_valid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.z_valid !== 1'b0 || bus.reset_counter_out !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0)
      begin n_bad++; $display("FAIL rstmid_ctl: got v=%b rc=%b done=%b busy=%b exp all 0", bus.z_valid, bus.reset_counter_out, bus.done, bus.busy); end
    n_cmp++; if (bus.z_to_z !== 48'h0) begin n_bad++; $display("FAIL rstmid_z: got %h exp 0", bus.z_to_z); end
    n_cmp++; if (bus.fill !== 4'd0 || bus.wr_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_fifo: got fill=%0d ready=%b exp 0 1", bus.fill, bus.wr_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.done || bus.z_valid || bus.busy) nd++;
    end
    n_cmp++; if (nd !== 0) begin n_bad++; $display("FAIL rstmid_no_done: got %0d active cycles exp 0", nd); end
  endtask

  task automatic test_back_to_back();
    int cyc, n_done, n_rc, rc1, rc2, nz, overlap;
    bit f1, f2;
    logic [15:0] v;
    push_row(mk_row(16'h0021, 16'h0022, 16'h0023));
    push_row(mk_row(16'h0024, 16'h0025, 16'h0026));
    push_row(mk_row(16'h0031, 16'h0032, 16'h0033));
    push_row(mk_row(16'h0034, 16'h0035, 16'h0036));
    bus.start = 1'b1; bus.frame_len = 4'd2;
    tick();
    bus.start = 1'b0;
    cyc = 1; n_done = 0; n_rc = 0; rc1 = 0; rc2 = 0; nz = 0; overlap = 0;
    for (int i = 0; i < 30 && n_done < 2; i++) begin
      if (bus.reset_counter_out) begin
        n_rc++;
        if (n_rc == 1) rc1 = cyc; else rc2 = cyc;
      end
      f1 = 1'b0; f2 = 1'b0;
      for (int k = 0; k < 3; k++) begin
        v = bus.z_to_z[47-16*k -: 16];
        if (v != 16'h0) nz++;
        if (v >= 16'h0021 && v <= 16'h0026) f1 = 1'b1;
        if (v >= 16'h0031 && v <= 16'h0036) f2 = 1'b1;
      end
      if (f1 && f2) overlap++;
      if (bus.done) begin
        n_done++;
        if (n_done == 1) begin bus.start = 1'b1; bus.frame_len = 4'd2; end
      end
      tick();
      bus.start = 1'b0;
      cyc++;
    end
    n_cmp++; if (n_done !== 2) begin n_bad++; $display("FAIL b2b_done_count: got %0d exp 2", n_done); end
    n_cmp++; if (n_rc !== 2) begin n_bad++; $display("FAIL b2b_rc_count: got %0d exp 2", n_rc); end
    n_cmp++; if (rc2 - rc1 !== 6) begin n_bad++; $display("FAIL b2b_rc_spacing: got %0d exp 6", rc2 - rc1); end
    n_cmp++; if (overlap !== 0) begin n_bad++; $display("FAIL b2b_overlap: got %0d exp 0", overlap); end
    n_cmp++; if (nz !== 12) begin n_bad++; $display("FAIL b2b_lane_slots: got %0d exp 12", nz); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_wait_stall();
    test_fifo_full_clamp();
    test_zero_len();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/z_stream_feeder.md
Name: z_stream_feeder

Overview:
Upstream stage of the backprop systolic array. It buffers incoming z rows, which are size lanes of data_size bits each, and releases them as frames. Each frame goes out as a diagonally skewed wavefront on z_to_z. The block also generates the reset_counter_in pulse that marks the start of each frame for the array's continuous_systolic chain, and a done pulse when the frame has fully left the skew lines.

Parameters:
data_size, 16, bit width of one lane element (fixed-point, opaque to this block)
size, 3, number of lanes; must match the downstream array
depth, 8, row FIFO depth; power of two, at least 2

Ports:
clk  in  1  clock; all state is updated on its rising edge
rst_n  in  1  asynchronous active-low reset
wr_valid  in  1  row write request
wr_ready  out  1  FIFO can accept a row; equals !full and does not depend on pops
wr_data  in  data_size*size  row; lane k occupies bits [data_size*(size-k)-1 -: data_size], so lane 0 is the MSB slice
start  in  1  single-cycle frame request
frame_len  in  $clog2(depth)+1  rows in the frame; sampled only when start is accepted
busy  out  1  high whenever the FSM is not in IDLE
z_to_z  out  data_size*size  skewed row stream to the array
z_valid  out  1  lane 0 of z_to_z carries a frame row this cycle
reset_counter_out  out  1  one-cycle frame-start pulse, drives the array's reset_counter_in
done  out  1  one-cycle pulse when the last lane of the last row has been emitted
fill  out  $clog2(depth)+1  current FIFO occupancy

Behaviour:
- Reset (asynchronous, rst_n low):
  - FIFO empties; fill is 0 and wr_ready is 1.
  - FSM goes to IDLE.
  - z_to_z, z_valid, reset_counter_out, done and busy are all 0.
  - All skew registers clear to 0.
  - Reset mid-frame abandons the frame and discards buffered rows. No done pulse is issued.
- FIFO push: a row is pushed when wr_valid and wr_ready are both high. A pop in the same cycle never frees space for that push.
- FIFO full: a write with wr_valid high is held off by wr_ready and nothing is dropped.
- FSM states: IDLE, WAIT, STREAM, DRAIN.
  - IDLE: start captures len = min(frame_len, depth).
    - If len is 0, go straight to DRAIN with the drain count preset to 0; done fires the next cycle.
    - Otherwise go to WAIT.
    - start is ignored in every state other than IDLE.
  - WAIT: stay until fill >= len, then go to STREAM. Rows arriving in that same cycle do not count.
  - STREAM: pop exactly one row per cycle for len cycles, then go to DRAIN.
  - DRAIN: wait size-1 cycles, then pulse done for one cycle and return to IDLE. With size=1, DRAIN lasts zero wait cycles and done fires on the cycle after the last pop.
- Latency:
  - A row popped in cycle t appears on lane k of z_to_z at cycle t+1+k.
  - z_valid is high at t+1.
  - Lanes carry 0 whenever their slot holds no frame row, including between frames and during DRAIN.
- reset_counter_out is high in the cycle where z_valid rises for the first row of a frame. It is a registered output, aligned with lane 0.
- Rows written while streaming are accepted and held for the next frame.
- busy goes low in the same cycle as the done pulse.

Optional Feature:
Macro Z_STREAM_FEEDER_STALL_CNT_EN.
- When defined: adds an output stall_cycles (32 bits).
  - Counts cycles spent in WAIT.
  - Saturates at all-ones.
  - Cleared by rst_n and on every accepted start.
- When not defined: the port and counter do not exist, and all other behaviour is identical.

Decomposition:
- Shared package backprop_pkg holds:
  - the feeder_state_t enum (IDLE, WAIT, STREAM, DRAIN);
  - a lane-slice function returning lane k of a data_size*size bus.
- Sub-module skew_line: one lane's k-stage shift register with asynchronous active-low reset.
  - It is needed because the existing delay block has no reset.
  - It is instantiated size times, with stage count k per lane (k=0 is a wire).

Test Plan:
- Push rows 0x0001_0002_0003, 0x0004_0005_0006 and 0x0007_0008_0009, then start with frame_len=3.
  - reset_counter_out and z_valid are high together.
  - Lane0 carries 1,4,7 starting at T; lane1 carries 2,5,8 starting at T+1; lane2 carries 3,6,9 starting at T+2.
  - done pulses at T+4 and busy drops in the same cycle.
- Start with frame_len=4 and only 2 rows buffered.
  - FSM holds in WAIT and z_valid stays 0.
  - Streaming begins 1 cycle after the 4th row is accepted.
  - With the macro defined, stall_cycles equals the cycles spent in WAIT.
- Fill the FIFO to 8 rows with wr_valid held high.
  - wr_ready goes low and the 9th row is not accepted.
  - A pop in that cycle does not admit it; it is accepted the following cycle.
- Start with frame_len=0: done pulses 1 cycle later and no z_valid or reset_counter_out is produced. Also check clamping:
  - frame_len=15 is clamped to 8.
  - A start while busy is ignored.
- Assert rst_n low in the middle of STREAM.
  - All outputs are immediately 0, fill is 0 and wr_ready is 1.
  - No done pulse follows.
- Run two back-to-back frames of 2 rows.
  - The second reset_counter_out follows the first at a spacing of len + size-1 + 2 cycles.
  - Lane data of the two frames never overlaps.
